base_wsplit: RTL
================

Name: base_wsplit

Overview:
- Downstream width-down converter for the large-FIFO output.
- Takes one wide word per valid/ready handshake and emits its first i_e+1 narrow beats, lowest slice first, on a valid/ready interface.
- Marks the final beat of each word with o_last.
- Holds one word and accepts the next word in the same cycle the last beat leaves, so back-to-back single-beat words sustain one word per cycle.

Parameters:
- owidth, 8, width of one output beat in bits.
- n, 4, beats per input word; must be at least 2; the input word is n*owidth bits.
- LOG_N, $clog2(n), width of the beat index and last-index fields.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_v  input  1  input word valid.
- i_r  output  1  input ready; a word transfers when i_v and i_r are both 1.
- i_d  input  n*owidth  input word; beat k is i_d[k*owidth +: owidth].
- i_e  input  LOG_N  index of the last valid beat in the word (0 means one beat).
- o_v  output  1  output beat valid.
- o_r  input  1  downstream ready; a beat transfers when o_v and o_r are both 1.
- o_d  output  owidth  current beat data.
- o_idx  output  LOG_N  index of the current beat within its word.
- o_last  output  1  current beat is the last beat of its word.

Behaviour:
- State:
  - hold_v: 1 bit.
  - hold_d: n*owidth bits.
  - hold_e: LOG_N bits.
  - cnt: LOG_N-bit beat counter.
- Reset, synchronous, effective on the first edge with reset=1:
  - hold_v=0 and cnt=0.
  - o_v=0, o_last=0 and o_idx=0 in the following cycle.
  - hold_d is not reset; o_d is don't-care while o_v=0.
- Outputs:
  - o_v=hold_v.
  - o_d=hold_d[cnt*owidth +: owidth].
  - o_idx=cnt.
  - o_last=hold_v & (cnt==hold_e).
  - All outputs are a register plus a mux; there is no combinational path from i_* to o_*.
- Input ready: i_r = ~hold_v | (o_r & o_last).
  - i_r depends combinationally on o_r only; i_r does not depend on i_v.
- Load: on an input transfer, hold_v=1, hold_d=i_d, hold_e=min(i_e, n-1) and cnt=0 at the next edge.
  - i_e values of n or more (possible only when n is not a power of two) are clamped to n-1.
- Latency: a word accepted at edge t presents beat 0 in cycle t+1.
- Beat advance: on an output transfer with o_last=0, cnt increments by 1 and hold_d is unchanged.
- Word completion: on an output transfer with o_last=1:
  - If an input transfer happens in the same cycle, the new word loads (cnt=0) with no bubble.
  - Otherwise hold_v=0 and cnt=0.
- Backpressure: while o_v=1 and o_r=0, o_d, o_idx and o_last stay stable. This is required by the downstream valid/ready contract.
- Throughput:
  - The output carries one beat per cycle when o_r=1 and input is available.
  - A word of e+1 beats occupies the block for e+1 cycles.
- i_d, i_e and i_v are ignored whenever i_r=0. The upstream FIFO holds them stable per its own contract; this block does not rely on that.
- Reset mid-word: the held word is discarded. Remaining beats are not emitted, and no partial o_last is produced.
- Data is never dropped or duplicated. Every accepted word produces exactly hold_e+1 output transfers, the last one with o_last=1.

Test Plan:
- n=4, owidth=8, i_d=32'hDDCCBBAA, i_e=3, o_r=1 held:
  - Beats AA, BB, CC, DD on 4 consecutive cycles starting the cycle after acceptance.
  - o_idx 0..3; o_last=1 only on DD.
  - i_r=0 during AA..CC, i_r=1 during DD.
- Back-to-back: words 32'h00002211 (i_e=1) and 32'h00004433 (i_e=1) offered continuously, o_r=1:
  - Output 11,22,33,44 on 4 consecutive cycles with no bubble.
  - o_last on 22 and 44.
  - The second word is accepted in the cycle 22 transfers.
- Single-beat stream: 8 words with i_e=0 and i_v=1 every cycle, o_r=1:
  - 8 output beats on 8 consecutive cycles, each with o_last=1 and o_idx=0.
  - i_r stays 1 throughout.
- Backpressure: during word 32'hDDCCBBAA, drop o_r for 3 cycles while o_d=BB:
  - o_d=BB and o_idx=1 stable for those 3 cycles, o_v=1, i_r=0.
  - Sequence resumes with BB, CC, DD once o_r=1, with no duplicates.
- Reset mid-word: assert reset for 1 cycle after AA transfers:
  - Next cycle o_v=0 and i_r=1.
  - Next word 32'h0000FFEE (i_e=1) yields EE, FF only; no remaining CC/DD appear.
- Clamp: n=3, LOG_N=2, i_e=3, i_d=24'h332211:
  - Beats 11, 22, 33 with o_last on 33 (idx 2); exactly 3 output transfers.

Source files
------------

// File: rtl/base_wsplit.sv
// base_wsplit: splits one wide word into its first i_e+1 narrow beats, lowest slice first, tagging the final beat with o_last.
// Latency: a word accepted at edge t presents beat 0 in cycle t+1; single-beat words stream at one word per cycle.
// Backpressure: o_r=0 freezes the current beat; i_r = ~hold_v | (o_r & o_last), so i_r never depends on i_v.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   i_v/i_r/i_d/i_e   wide-word valid/ready, data (n*owidth), last beat index
//   o_v/o_r/o_d       narrow-beat valid/ready, data (owidth)
//   o_idx, o_last     beat index within its word, final-beat flag
module base_wsplit #(
  parameter int owidth = 8,
  parameter int n      = 4,
  parameter int LOG_N  = $clog2(n)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_v,
  output logic                  i_r,
  input  logic [n*owidth-1:0]   i_d,
  input  logic [LOG_N-1:0]      i_e,
  output logic                  o_v,
  input  logic                  o_r,
  output logic [owidth-1:0]     o_d,
  output logic [LOG_N-1:0]      o_idx,
  output logic                  o_last
);

  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(n - 1);

  logic                r_hold_v;
  logic [n*owidth-1:0] r_hold_d;
  logic [LOG_N-1:0]    r_hold_e;
  logic [LOG_N-1:0]    r_cnt;

  logic                w_last;
  logic                w_in_fire;
  logic                w_out_fire;
  logic [LOG_N-1:0]    w_e_clamp;
  logic [owidth-1:0]   w_od;

  assign w_last     = r_hold_v & (r_cnt == r_hold_e);
  assign i_r        = ~r_hold_v | (o_r & w_last);
  assign w_in_fire  = i_v & i_r;
  assign w_out_fire = r_hold_v & o_r;

  // Indices beyond the last slice only exist when n is not a power of two;
  // clamping keeps the beat counter inside the word.
  assign w_e_clamp  = (i_e >= LAST_IDX) ? LAST_IDX : i_e;

  // Slice select; cnt never exceeds hold_e, so every reachable index is covered.
  always_comb begin
    w_od = '0;
    for (int k = 0; k < n; k++) begin
      if (r_cnt == LOG_N'(k)) begin
        w_od = r_hold_d[k*owidth +: owidth];
      end
    end
  end

  // Control state: a new load takes priority, which is what lets the next
  // word enter in the same cycle the last beat of the current one leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_v <= 1'b0;
      r_cnt    <= '0;
    end else if (w_in_fire) begin
      r_hold_v <= 1'b1;
      r_cnt    <= '0;
    end else if (w_out_fire) begin
      if (w_last) begin
        r_hold_v <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_cnt    <= r_cnt + LOG_N'(1);
      end
    end
  end

  // Word payload needs no reset: it is only observed while hold_v is set.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_hold_d <= i_d;
      r_hold_e <= w_e_clamp;
    end
  end

  assign o_v    = r_hold_v;
  assign o_d    = w_od;
  assign o_idx  = r_cnt;
  assign o_last = w_last;

endmodule
